// File: rtl/stream_sort_engine.sv
`default_nettype none
// ============================================================================
// Module   : stream_sort_engine
// Purpose  : Streaming frame sorter. Loads up to 2**LOG_N words over a
//            valid/ready stream, sorts them in place with an iterative
//            odd-even transposition engine (N phases), then drains the frame
//            in sorted order over a valid/ready stream.
// Revision : 1.0  initial release
// ============================================================================
module stream_sort_engine #(
   parameter int LOG_N      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int SIGNED     = 0,
   parameter int ASCENDING  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic [LOG_N:0]        m_len,
   output logic                  busy
);

   localparam int N  = 2 ** LOG_N;
   localparam int CW = LOG_N + 1;

   localparam logic [CW-1:0] C_LAST_IDX = CW'(N - 1);

   // Padding value that always sorts to the tail, so it never reaches the output.
   localparam logic [DATA_WIDTH-1:0] C_SENT =
      (ASCENDING != 0) ? ((SIGNED != 0) ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : {DATA_WIDTH{1'b1}})
                       : ((SIGNED != 0) ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {DATA_WIDTH{1'b0}});

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SORT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                state_q;
   logic [DATA_WIDTH-1:0] mem_q  [N];
   logic [DATA_WIDTH-1:0] sort_d [N];
   logic [CW-1:0]         wr_cnt_q;
   logic [CW-1:0]         rd_cnt_q;
   logic [CW-1:0]         phase_q;
   logic [CW-1:0]         len_q;
   logic                  m_valid_q;
   logic [DATA_WIDTH-1:0] m_data_q;
   logic                  m_last_q;
   logic [CW-1:0]         m_len_q;

   logic                  w_close;
   logic [CW-1:0]         w_rd_nxt;

   // a sits at the lower index; return 1 when the pair must be exchanged.
   function automatic logic f_swap(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
      logic a_gt_b;
      logic b_gt_a;
      if (SIGNED != 0) begin
         a_gt_b = ($signed(a) > $signed(b));
         b_gt_a = ($signed(b) > $signed(a));
      end else begin
         a_gt_b = (a > b);
         b_gt_a = (b > a);
      end
      return (ASCENDING != 0) ? a_gt_b : b_gt_a;
   endfunction

   assign s_ready  = (state_q == ST_LOAD) && !rst;
   assign busy     = (state_q != ST_LOAD);
   assign m_valid  = m_valid_q;
   assign m_data   = m_data_q;
   assign m_last   = m_last_q;
   assign m_len    = m_len_q;

   assign w_close  = s_last || (wr_cnt_q == C_LAST_IDX);
   assign w_rd_nxt = rd_cnt_q + CW'(1);

   // One compare-exchange phase: even phase pairs start at 0, odd phase at 1.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         sort_d[i] = mem_q[i];
      end
      for (int i = 0; i < N - 1; i++) begin
         if (i[0] == phase_q[0]) begin
            if (f_swap(mem_q[i], mem_q[i+1])) begin
               sort_d[i]   = mem_q[i+1];
               sort_d[i+1] = mem_q[i];
            end
         end
      end
   end

   // Control FSM, frame buffer and registered output stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_LOAD;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         phase_q   <= '0;
         len_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         m_len_q   <= '0;
         for (int i = 0; i < N; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (s_valid) begin
                  for (int i = 0; i < N; i++) begin
                     if (CW'(i) == wr_cnt_q) begin
                        mem_q[i] <= s_data;
                     end else if (w_close && (CW'(i) > wr_cnt_q)) begin
                        mem_q[i] <= C_SENT;
                     end
                  end
                  if (w_close) begin
                     len_q    <= wr_cnt_q + CW'(1);
                     wr_cnt_q <= '0;
                     phase_q  <= '0;
                     state_q  <= ST_SORT;
                  end else begin
                     wr_cnt_q <= wr_cnt_q + CW'(1);
                  end
               end
            end

            ST_SORT: begin
               for (int i = 0; i < N; i++) begin
                  mem_q[i] <= sort_d[i];
               end
               if (phase_q == C_LAST_IDX) begin
                  phase_q  <= '0;
                  rd_cnt_q <= '0;
                  state_q  <= ST_DRAIN;
               end else begin
                  phase_q <= phase_q + CW'(1);
               end
            end

            ST_DRAIN: begin
               if (!m_valid_q) begin
                  // First drain cycle primes the output register with slot 0.
                  m_valid_q <= 1'b1;
                  m_data_q  <= mem_q[0];
                  m_last_q  <= (len_q == CW'(1));
                  m_len_q   <= len_q;
               end else if (m_ready) begin
                  if (m_last_q) begin
                     m_valid_q <= 1'b0;
                     m_data_q  <= '0;
                     m_last_q  <= 1'b0;
                     m_len_q   <= '0;
                     rd_cnt_q  <= '0;
                     state_q   <= ST_LOAD;
                  end else begin
                     rd_cnt_q <= w_rd_nxt;
                     m_data_q <= mem_q[w_rd_nxt[LOG_N-1:0]];
                     m_last_q <= (w_rd_nxt == (len_q - CW'(1)));
                  end
               end
            end

            default: begin
               state_q <= ST_LOAD;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_stream_sort_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_sort_engine
// Purpose  : Directed self-checking bench for stream_sort_engine. Two
//            instances share the input stream: u_dut0 (32b unsigned
//            ascending) and u_dut1 (8b signed descending).
// Revision : 1.0  initial release
// ============================================================================
module tb_stream_sort_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_last = 1'b0;
   logic        m_ready = 1'b1;
   logic        sel = 1'b0;

   logic        s_ready0, s_ready1, m_valid0, m_valid1, m_last0, m_last1, busy0, busy1;
   logic [31:0] m_data0;
   logic [7:0]  m_data1;
   logic [4:0]  m_len0, m_len1;

   logic        s_ready, m_valid, m_last, busy;
   logic [31:0] m_data;
   logic [4:0]  m_len;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int last_acc = 0;

   typedef struct {
      logic [15:0][31:0] din;
      logic [15:0][31:0] exp;
      int                len;
      bit                use_last;
      bit                sel;
   } vec_t;

   vec_t              tv [6];
   logic [15:0][31:0] ev;

   stream_sort_engine #(.LOG_N(4), .DATA_WIDTH(32), .SIGNED(0), .ASCENDING(1)) u_dut0 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
      .s_last(s_last), .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0),
      .m_last(m_last0), .m_len(m_len0), .busy(busy0));

   stream_sort_engine #(.LOG_N(4), .DATA_WIDTH(8), .SIGNED(1), .ASCENDING(0)) u_dut1 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data[7:0]),
      .s_last(s_last), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
      .m_last(m_last1), .m_len(m_len1), .busy(busy1));

   assign s_ready = sel ? s_ready1 : s_ready0;
   assign m_valid = sel ? m_valid1 : m_valid0;
   assign m_data  = sel ? {24'h0, m_data1} : m_data0;
   assign m_last  = sel ? m_last1 : m_last0;
   assign m_len   = sel ? m_len1 : m_len0;
   assign busy    = sel ? busy1 : busy0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [31:0] d, input bit l);
      int t = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (!s_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("send_timeout", 32'(s_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      last_acc = cyc;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input vec_t v);
      for (int k = 0; k < v.len; k++) begin
         send(v.din[k], v.use_last && (k == v.len - 1));
      end
   endtask

   // Collect `take` beats of a frame of `len` elements; mode 1 applies backpressure.
   task automatic recv(input int len, input int take, input int mode, input bit chk_lat);
      int  got = 0;
      int  jv = 0;
      int  t = 0;
      bit  stalled = 1'b0;
      bit  first = 1'b1;
      logic [31:0] hd;
      logic        hl;
      while (got < take && t < 400) begin
         @(negedge clk);
         t++;
         if (stalled) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", m_data, hd);
            chk("stall_last", 32'(m_last), 32'(hl));
         end
         if (m_valid) begin
            if (first && chk_lat) chk("latency", 32'(cyc - last_acc), 32'd17);
            first = 1'b0;
            if (mode == 1) m_ready = (jv >= 2 && jv <= 6) ? 1'b0 : (jv % 2 == 0);
            else           m_ready = 1'b1;
            jv++;
            if (m_ready) begin
               chk("data", m_data, ev[got]);
               chk("last", 32'(m_last), 32'(got == len - 1));
               chk("len", 32'(m_len), 32'(len));
               got++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               hd = m_data;
               hl = m_last;
            end
         end
      end
      if (got < take) chk("recv_timeout", 32'(got), 32'(take));
      m_ready = 1'b1;
   endtask

   task automatic post_frame();
      @(negedge clk);
      chk("post_s_ready", 32'(s_ready), 32'd1);
      chk("post_m_valid", 32'(m_valid), 32'd0);
      chk("post_m_len", 32'(m_len), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_m_valid"}, 32'(m_valid0 | m_valid1), 32'd0);
      chk({tag, "_m_data"}, m_data0 | {24'h0, m_data1}, 32'd0);
      chk({tag, "_m_last"}, 32'(m_last0 | m_last1), 32'd0);
      chk({tag, "_m_len"}, 32'(m_len0 | m_len1), 32'd0);
      chk({tag, "_busy"}, 32'(busy0 | busy1), 32'd0);
      chk({tag, "_s_ready"}, 32'(s_ready0 | s_ready1), 32'd0);
   endtask

   task automatic set5(input int i, input bit sl,
                       input logic [31:0] d0, d1, d2, d3, d4,
                       input logic [31:0] e0, e1, e2, e3, e4);
      tv[i].din = '0;
      tv[i].exp = '0;
      tv[i].len = 5;
      tv[i].use_last = 1'b1;
      tv[i].sel = sl;
      tv[i].din[0] = d0; tv[i].din[1] = d1; tv[i].din[2] = d2;
      tv[i].din[3] = d3; tv[i].din[4] = d4;
      tv[i].exp[0] = e0; tv[i].exp[1] = e1; tv[i].exp[2] = e2;
      tv[i].exp[3] = e3; tv[i].exp[4] = e4;
   endtask

   initial begin
      // Vector table
      for (int t = 0; t < 2; t++) begin
         tv[t].len = 16;
         tv[t].use_last = (t == 0);
         tv[t].sel = 1'b0;
         for (int k = 0; k < 16; k++) begin
            tv[t].din[k] = 32'(15 - k);
            tv[t].exp[k] = 32'(k);
         end
      end
      set5(2, 1'b0, 32'd9, 32'd3, 32'd7, 32'd1, 32'd5,
                    32'd1, 32'd3, 32'd5, 32'd7, 32'd9);
      set5(3, 1'b1, 32'hFD, 32'h0A, 32'h00, 32'h80, 32'h0A,
                    32'h0A, 32'h0A, 32'h00, 32'hFD, 32'h80);
      set5(4, 1'b0, 32'd5, 32'd5, 32'hFFFFFFFF, 32'd0, 32'd2,
                    32'd0, 32'd2, 32'd5, 32'd5, 32'hFFFFFFFF);
      tv[5].din = '0;
      tv[5].exp = '0;
      tv[5].len = 1;
      tv[5].use_last = 1'b1;
      tv[5].sel = 1'b0;
      tv[5].din[0] = 32'hDEADBEEF;
      tv[5].exp[0] = 32'hDEADBEEF;

      // Reset state
      repeat (3) @(negedge clk);
      chk_zero_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("reset_release_s_ready", 32'(s_ready0 & s_ready1), 32'd1);
      chk("reset_release_busy", 32'(busy0 | busy1), 32'd0);

      // Table-driven frames
      for (int t = 0; t < 6; t++) begin
         sel = tv[t].sel;
         ev  = tv[t].exp;
         send_frame(tv[t]);
         recv(tv[t].len, tv[t].len, 0, 1'b1);
         post_frame();
      end

      // Backpressure on the partial frame
      sel = 1'b0;
      ev  = tv[2].exp;
      send_frame(tv[2]);
      recv(5, 5, 1, 1'b1);
      post_frame();

      // Reset during SORT phase 3
      send_frame(tv[2]);
      repeat (3) @(negedge clk);
      chk("sort_busy_before_rst", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk_zero_outputs("rst_sort");
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_sort_s_ready", 32'(s_ready), 32'd1);
      @(negedge clk);
      send_frame(tv[2]);
      recv(5, 5, 0, 1'b1);
      post_frame();

      // Reset while DRAIN presents beat 2
      send_frame(tv[2]);
      recv(5, 2, 0, 1'b1);
      @(negedge clk);
      chk("drain_beat2_data", m_data, 32'd5);
      rst = 1'b1;
      #1;
      chk_zero_outputs("rst_drain");
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_drain_s_ready", 32'(s_ready), 32'd1);
      @(negedge clk);
      send_frame(tv[2]);
      recv(5, 5, 0, 1'b1);
      post_frame();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
